// File: rtl/rr_decode_arbiter_4_if.sv
// Request/grant bundle between request sources and the round-robin arbiter.
// req is level-held by a requester while it wants the resource; grant is a
// registered one-hot select that stays stable until the owner drops req,
// en falls, or the hold timeout fires. There is no per-beat valid/ready:
// req is the request level and grant is the standing acknowledgement.
interface rr_decode_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  preempt
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output preempt
  );
endinterface

// File: rtl/rr_decode_arbiter_4.sv
// Four-way round-robin arbiter: registered owner index decoded to an en-gated
// one-hot grant, with hold timeout preemption and a one-cycle turnaround gap.
module rr_decode_arbiter_4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_decode_arbiter_4_if.slave  bus,
  output logic [1:0]            state_o
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        grant_idx_q, grant_idx_d;
  logic              grant_valid_q, grant_valid_d;
  logic              preempt_q, preempt_d;

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              others_wait;

  function automatic logic [3:0] decode2to4(input logic [1:0] idx, input logic en);
    decode2to4 = en ? (4'b0001 << idx) : 4'b0000;
  endfunction

  // Scan offsets high to low so the lowest offset from start wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] cand;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (req[cand]) rr_pick = {1'b1, cand};
    end
  endfunction

  assign {pick_found, pick_idx} = rr_pick(bus.req, ptr_q);
  assign others_wait = |(bus.req & ~grant_q);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;

    case (state_q)
      ST_GRANT: begin
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
        if (!bus.en) begin
          state_d       = ST_IDLE;
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
        end else if (!bus.req[grant_idx_q]) begin
          state_d       = ST_GAP;
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          ptr_d         = grant_idx_q + 2'd1;
        end else if ((hold_cnt_q >= HOLD_LAST) && others_wait) begin
          // >= rather than == so a late arrival after saturation still preempts.
          state_d       = ST_GAP;
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          ptr_d         = grant_idx_q + 2'd1;
          preempt_d     = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = 4'b0000;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
        if (bus.en && pick_found) begin
          state_d       = ST_GRANT;
          grant_idx_d   = pick_idx;
          grant_d       = decode2to4(pick_idx, bus.en);
          grant_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.preempt     = preempt_q;
  assign state_o         = state_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_valid:  assert property (@(posedge clk) disable iff (rst) grant_valid_q == (|grant_q));
  a_index:  assert property (@(posedge clk) disable iff (rst)
                             grant_valid_q |-> (grant_q == (4'b0001 << grant_idx_q)));

endmodule

// File: tb/tb_rr_decode_arbiter_4.sv
// Directed bench for rr_decode_arbiter_4: vector table plus hand-written
// sequences for round-robin rotation, hold timeout and async reset.
module tb_rr_decode_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       prev_pre = 1'b0;

  rr_decode_arbiter_4_if bus ();

  rr_decode_arbiter_4 #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       chk_idx;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] idx,
                            input logic chk_idx, input logic valid, input logic pre);
    chk({name, ".grant"}, 32'(bus.grant), 32'(g));
    chk({name, ".valid"}, 32'(bus.grant_valid), 32'(valid));
    chk({name, ".preempt"}, 32'(bus.preempt), 32'(pre));
    if (chk_idx) chk({name, ".idx"}, 32'(bus.grant_idx), 32'(idx));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] g,
                         input logic [1:0] ix, input logic ci, input logic v, input logic p);
    vec_t t;
    t.rst = r; t.en = e; t.req = rq; t.g = g; t.idx = ix; t.chk_idx = ci; t.valid = v; t.pre = p;
    vecs.push_back(t);
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    chk("inv_onehot", 32'($onehot0(bus.grant)), 32'd1);
    chk("inv_valid", 32'(bus.grant_valid), 32'(|bus.grant));
    if (bus.grant_valid) chk("inv_idx", 32'(bus.grant), 32'(4'b0001 << bus.grant_idx));
    chk("inv_pre2", 32'(prev_pre && bus.preempt), 32'd0);
    prev_pre = bus.preempt;
  end

  initial begin
    logic [3:0] rq;
    int         ix;

    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 4'b1111;

    // Reset with all requests up, then a sole requester held 20 cycles.
    add_vec(1, 0, 4'b1111, 4'b0000, 2'd0, 1, 0, 0);
    add_vec(1, 1, 4'b1111, 4'b0000, 2'd0, 1, 0, 0);
    add_vec(0, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 0);
    for (int i = 0; i < 20; i++) add_vec(0, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);  // release -> gap, ptr=3
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);  // idle
    // Owner idx3, en low three cycles, ptr must stay at 3.
    add_vec(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 1, 0);
    add_vec(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 1, 0);
    add_vec(0, 0, 4'b1000, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 0, 4'b1000, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 0, 4'b1000, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 1, 4'b1001, 4'b1000, 2'd3, 1, 1, 0);
    add_vec(0, 1, 4'b1001, 4'b1000, 2'd3, 1, 1, 0);
    // idx3 releases (ptr=0); en low during gap blocks a grant.
    add_vec(0, 1, 4'b0001, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 0, 4'b0001, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 1, 4'b0001, 4'b0001, 2'd0, 1, 1, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);  // ptr=1
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    // Simultaneous 1001 with ptr=1 -> idx3, not idx0.
    add_vec(0, 1, 4'b1001, 4'b1000, 2'd3, 1, 1, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);  // ptr=0
    // Non-owner request churn must not disturb idx1.
    add_vec(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 0);
    add_vec(0, 1, 4'b0111, 4'b0010, 2'd1, 1, 1, 0);
    add_vec(0, 1, 4'b1010, 4'b0010, 2'd1, 1, 1, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);  // ptr=2
    add_vec(0, 1, 4'b0011, 4'b0001, 2'd0, 1, 1, 0);  // from gap, search 2,3,0
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      bus.en  = vecs[i].en;
      bus.req = vecs[i].req;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx, vecs[i].chk_idx,
                 vecs[i].valid, vecs[i].pre);
    end

    // Round-robin rotation: each owner drops 3 cycles after grant, re-raises in the gap.
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0000;
    step();
    rst = 1'b0; bus.en = 1'b1; rq = 4'b1111; bus.req = rq;
    step();
    for (int n = 0; n < 5; n++) begin
      ix = n % 4;
      for (int c = 0; c < 3; c++) begin
        expect_out($sformatf("rr%0d_c%0d", n, c), 4'(4'b0001 << ix), 2'(ix), 1, 1, 0);
        if (c < 2) step();
      end
      rq[ix] = 1'b0; bus.req = rq;
      step();
      expect_out($sformatf("rr%0d_gap", n), 4'b0000, 2'd0, 0, 0, 0);
      rq[ix] = 1'b1; bus.req = rq;
      step();
    end

    // Hold timeout between two persistent requesters.
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0000;
    step();
    rst = 1'b0; bus.en = 1'b1; bus.req = 4'b0011;
    for (int own = 0; own < 2; own++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        expect_out($sformatf("to%0d_c%0d", own, c), 4'(4'b0001 << own), 2'(own), 1, 1, 0);
      end
      step();
      expect_out($sformatf("to%0d_pre", own), 4'b0000, 2'd0, 0, 0, 1);
    end
    step();
    expect_out("to_back0", 4'b0001, 2'd0, 1, 1, 0);

    // Async reset mid-grant with ptr moved to 2 first.
    rst = 1'b1; bus.req = 4'b0000;
    step();
    rst = 1'b0; bus.en = 1'b1; bus.req = 4'b0010;
    step();
    expect_out("ar_own1", 4'b0010, 2'd1, 1, 1, 0);
    bus.req = 4'b0000;
    step();
    expect_out("ar_gap", 4'b0000, 2'd0, 0, 0, 0);
    bus.req = 4'b0100;
    step();
    expect_out("ar_own2", 4'b0100, 2'd2, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("ar_async", 4'b0000, 2'd0, 1, 0, 0);
    rst = 1'b0; bus.req = 4'b1010;
    step();
    expect_out("ar_ptr0", 4'b0010, 2'd1, 1, 1, 0);
    bus.req = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
